// File: rtl/switch_press_counter_pkg.sv
// Board-level constants shared by every debounced push-button input.
package switch_press_counter_pkg;

  localparam int CLK_FREQ_HZ = 25_000_000;
  localparam int DEBOUNCE_MS = 10;

  function automatic int debounce_cycles(input int freq_hz, input int ms);
    return (freq_hz / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_LIMIT_DEF = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/debounce_switch.sv
// Two-flop synchroniser plus stable-count filter for one raw push-button.
module debounce_switch
  import switch_press_counter_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          r_Sync1;
  logic          r_Sync2;
  logic          r_Stable;
  logic [CW-1:0] r_Db_Cnt;

  // Any sample matching the accepted level restarts the run, so glitches never accumulate.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Sync1  <= 1'b0;
      r_Sync2  <= 1'b0;
      r_Stable <= 1'b0;
      r_Db_Cnt <= '0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
      if (r_Sync2 == r_Stable) begin
        r_Db_Cnt <= '0;
      end else if (r_Db_Cnt == CNT_LAST) begin
        r_Stable <= r_Sync2;
        r_Db_Cnt <= '0;
      end else begin
        r_Db_Cnt <= r_Db_Cnt + CW'(1);
      end
    end
  end

  assign o_Switch = r_Stable;

endmodule

// File: rtl/switch_press_counter.sv
// Counts debounced button releases into an 8-bit wrapping count for the hex display.
module switch_press_counter
  import switch_press_counter_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  input  logic       i_Clear,
  output logic       o_Switch_Debounced,
  output logic       o_Press_Pulse,
  output logic [7:0] o_Count,
  output logic [3:0] o_Ones_Nibble,
  output logic [3:0] o_Tens_Nibble
);

  logic r_Stable;
  logic r_Stable_D;
  logic release_evt;

  debounce_switch #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_debounce (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Switch(r_Stable)
  );

  assign release_evt = r_Stable_D & ~r_Stable;

  // Clear wins over a coincident release; that release is dropped.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Stable_D    <= 1'b0;
      o_Count       <= 8'h00;
      o_Press_Pulse <= 1'b0;
    end else begin
      r_Stable_D <= r_Stable;
      if (i_Clear) begin
        o_Count       <= 8'h00;
        o_Press_Pulse <= 1'b0;
      end else if (release_evt) begin
        o_Count       <= o_Count + 8'd1;
        o_Press_Pulse <= 1'b1;
      end else begin
        o_Press_Pulse <= 1'b0;
      end
    end
  end

  assign o_Switch_Debounced = r_Stable;
  assign o_Ones_Nibble      = o_Count[3:0];
  assign o_Tens_Nibble      = o_Count[7:4];

endmodule

// File: tb/tb_switch_press_counter.sv
// Randomised and directed check of switch_press_counter against a window-based reference model.
module tb_switch_press_counter;

  localparam int LIM = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Switch = 1'b0;
  logic       i_Clear = 1'b0;
  logic       o_Switch_Debounced;
  logic       o_Press_Pulse;
  logic [7:0] o_Count;
  logic [3:0] o_Ones_Nibble;
  logic [3:0] o_Tens_Nibble;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: raw samples seen at each edge, accepted level, counter.
  bit       q[$];
  bit       m_stable = 0;
  bit       m_stable_d = 0;
  bit [7:0] m_count = 0;
  bit       m_pulse = 0;

  switch_press_counter #(.DEBOUNCE_LIMIT(LIM)) dut (
    .i_Clk             (i_Clk),
    .i_Rst_L           (i_Rst_L),
    .i_Switch          (i_Switch),
    .i_Clear           (i_Clear),
    .o_Switch_Debounced(o_Switch_Debounced),
    .o_Press_Pulse     (o_Press_Pulse),
    .o_Count           (o_Count),
    .o_Ones_Nibble     (o_Ones_Nibble),
    .o_Tens_Nibble     (o_Tens_Nibble)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < LIM + 2; i++) q.push_back(1'b0);
    m_stable = 0; m_stable_d = 0; m_count = 0; m_pulse = 0;
  endfunction

  // A new level is accepted once the synchronised input (two samples late)
  // has shown it for LIM consecutive edges; a release is a 1->0 of that level.
  function automatic void model_edge(input bit sw, input bit clr);
    bit all_new = 1;
    bit old_st = m_stable;
    bit rel = m_stable_d && !m_stable;
    for (int i = 0; i < LIM; i++)
      if (q[q.size() - 2 - i] == m_stable) all_new = 0;
    if (clr) begin
      m_count = 0; m_pulse = 0;
    end else if (rel) begin
      m_count = m_count + 8'd1; m_pulse = 1;
    end else begin
      m_pulse = 0;
    end
    m_stable_d = old_st;
    if (all_new) m_stable = !m_stable;
    q.push_back(sw);
    void'(q.pop_front());
  endfunction

  task automatic step(input bit sw, input bit clr, input bit rst);
    i_Switch = sw; i_Clear = clr; i_Rst_L = !rst;
    @(posedge i_Clk);
    if (rst) model_reset(); else model_edge(sw, clr);
    #1;
    chk("debounced", o_Switch_Debounced, m_stable);
    chk("pulse", o_Press_Pulse, m_pulse);
    chk("count", o_Count, m_count);
    chk("ones", o_Ones_Nibble, m_count % 16);
    chk("tens", o_Tens_Nibble, m_count / 16);
  endtask

  task automatic press_release();
    repeat (8) step(1, 0, 0);
    repeat (8) step(0, 0, 0);
  endtask

  // Edges of held high level until o_Switch_Debounced first reads 1.
  task automatic rise_latency(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0);
      if (lat == 0 && o_Switch_Debounced) lat = k;
    end
  endtask

  initial begin
    int lat, fl, pl, np, base;
    model_reset();

    // Reset held with the button pressed
    repeat (3) begin
      step(1, 0, 1);
      chk("rst_deb", o_Switch_Debounced, 0);
      chk("rst_count", o_Count, 0);
      chk("rst_pulse", o_Press_Pulse, 0);
    end
    rise_latency(lat);
    chk("rst_rise_lat", lat, 6);
    chk("rst_count_hold", o_Count, 0);
    repeat (8) step(0, 0, 0);
    step(0, 1, 0);

    // Clean press and release
    rise_latency(lat);
    chk("press_rise_lat", lat, 6);
    fl = 0; pl = 0; np = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0);
      if (fl == 0 && !o_Switch_Debounced) fl = k;
      if (o_Press_Pulse) begin np++; if (pl == 0) pl = k; end
    end
    chk("fall_lat", fl, 6);
    chk("pulse_lat", pl, 7);
    chk("pulse_width", np, 1);
    chk("clean_count", o_Count, 1);

    // Bounce rejection
    step(0, 1, 0);
    np = 0; fl = 0;
    for (int p = 0; p < 4; p++)
      repeat (3) begin
        step(!p[0], 0, 0);
        if (o_Switch_Debounced) fl = 1;
        if (o_Press_Pulse) np++;
      end
    repeat (10) begin
      step(0, 0, 0);
      if (o_Switch_Debounced) fl = 1;
      if (o_Press_Pulse) np++;
    end
    chk("bounce_deb", fl, 0);
    chk("bounce_pulse", np, 0);
    chk("bounce_count", o_Count, 0);

    // Wrap and nibbles
    repeat (17) press_release();
    chk("cnt_0x11", o_Count, 8'h11);
    chk("tens_1", o_Tens_Nibble, 1);
    chk("ones_1", o_Ones_Nibble, 1);
    step(0, 1, 0);
    repeat (255) press_release();
    chk("cnt_0xff", o_Count, 8'hff);
    repeat (8) step(1, 0, 0);
    np = 0;
    repeat (8) begin
      step(0, 0, 0);
      if (o_Press_Pulse) np++;
    end
    chk("wrap_count", o_Count, 0);
    chk("wrap_pulse", np, 1);

    // Clear coincident with a release
    step(0, 1, 0);
    repeat (5) press_release();
    chk("pre_clear", o_Count, 5);
    repeat (8) step(1, 0, 0);
    for (int k = 0; k < 20 && !(m_stable_d && !m_stable); k++) step(0, 0, 0);
    chk("clr_deb_low", o_Switch_Debounced, 0);
    step(0, 1, 0);
    chk("clr_count", o_Count, 0);
    chk("clr_pulse", o_Press_Pulse, 0);
    repeat (4) step(0, 0, 0);
    press_release();
    chk("after_clr", o_Count, 1);

    // Reset mid-debounce
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    chk("mid_rst_count", o_Count, 0);
    rise_latency(lat);
    chk("mid_rst_lat", lat, 6);
    repeat (8) step(0, 0, 0);

    // Random segments with occasional clear and reset
    base = 0;
    for (int s = 0; s < 400; s++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++)
        step(lvl, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
      if (o_Press_Pulse) base++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/switch_press_counter.md
# switch_press_counter

Upstream feeder for the board's hex seven-segment decoders. It synchronises and debounces one push-button and counts its releases in an 8-bit wrapping counter. The count is presented as two 4-bit nibbles: o_Ones_Nibble drives the right-hand decoder and o_Tens_Nibble drives the left-hand decoder. Display range is 0x00–0xFF.

## Interface
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles required before a new switch level is accepted (10 ms at 25 MHz); legal range ≥ 2.
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_L  input  1  reset, synchronous, active-low.
- i_Switch  input  1  raw push-button level, asynchronous, active-high.
- i_Clear  input  1  synchronous count clear, active-high; already in the i_Clk domain.
- o_Switch_Debounced  output  1  accepted switch level.
- o_Press_Pulse  output  1  one-cycle strobe, high in the cycle the count increments.
- o_Count  output  8  release count.
- o_Ones_Nibble  output  4  o_Count[3:0].
- o_Tens_Nibble  output  4  o_Count[7:4].

## Operation
- Synchroniser: two flops, r_Sync1 then r_Sync2. Only r_Sync2 feeds the filter.
- Debounce filter, one state bit r_Stable plus counter r_Db_Cnt of width $clog2(DEBOUNCE_LIMIT). On each edge:
  - r_Sync2 == r_Stable: r_Db_Cnt <= 0.
  - r_Sync2 != r_Stable and r_Db_Cnt < DEBOUNCE_LIMIT-1: r_Db_Cnt increments.
  - r_Sync2 != r_Stable and r_Db_Cnt == DEBOUNCE_LIMIT-1: r_Stable <= r_Sync2, r_Db_Cnt <= 0.
- Any glitch shorter than the limit restarts the count, so no change is accepted.
- o_Switch_Debounced = r_Stable.
- Edge detect: r_Stable_D is r_Stable delayed one cycle. A release is r_Stable_D=1 and r_Stable=0.
- Counter update, in priority order:
  - i_Clear=1: o_Count <= 0, o_Press_Pulse <= 0.
  - Else on release: o_Count <= o_Count+1, modulo 256, so 0xFF wraps to 0x00; o_Press_Pulse <= 1.
  - Else: o_Count holds, o_Press_Pulse <= 0.
- A press (rising debounced edge) has no effect on the count.

## Timing
- Reset (i_Rst_L=0 at a rising edge) clears:
  - r_Sync1, r_Sync2, r_Stable, r_Stable_D, r_Db_Cnt, o_Count and o_Press_Pulse to 0;
  - consequently o_Ones_Nibble and o_Tens_Nibble read 0.
- Reset mid-debounce discards the partial count. A switch still held high after reset is accepted DEBOUNCE_LIMIT+2 edges after release of reset.
- Switch to debounced latency: o_Switch_Debounced changes on the (DEBOUNCE_LIMIT+2)th rising edge after the edge on which i_Switch is first sampled at its new level. The level must be held the whole time.
- Debounced fall to count:
  - o_Count increments and o_Press_Pulse asserts on the edge after o_Switch_Debounced falls, i.e. one cycle later;
  - o_Press_Pulse is high for exactly one cycle.
- Total raw-release to count latency: DEBOUNCE_LIMIT+3 cycles.
- i_Clear takes effect on the next edge and has no latency beyond one cycle.
- i_Clear coincident with a release: the count goes to 0 and the release is lost (no pulse).
- Nibble outputs are continuous slices of o_Count with no added delay. The downstream decoder adds its own one-cycle register.
- Maximum count rate: one increment per 2×DEBOUNCE_LIMIT cycles, since every press and release must each be debounced.

## Structure
- Shared constants package/header:
  - CLK_FREQ_HZ (25_000_000);
  - DEBOUNCE_MS (10);
  - derived DEBOUNCE_LIMIT default, used by this block and any other switch input.
- Natural sub-module: debounce_switch. It contains the synchroniser and the filter, with ports i_Clk, i_Rst_L, i_Switch, o_Switch. It is instantiated once here and is reusable for the remaining board buttons.
- Top: edge detect, counter and nibble split.

## Test plan
All scenarios run with DEBOUNCE_LIMIT=4.
- Reset: hold i_Rst_L=0 for 3 cycles with i_Switch=1, then release reset. Outputs are all 0 during reset. o_Switch_Debounced rises 6 edges after reset release; o_Count stays 0.
- Clean press/release: high for 10 cycles, then low. o_Switch_Debounced rises 6 edges after the press and falls 6 edges after the release. o_Press_Pulse is high 1 cycle, one edge later, and o_Count goes 0→1.
- Bounce rejection: i_Switch toggles 1,0,1,0 with 3-cycle pulses, then stays low. o_Switch_Debounced never rises; o_Count stays 0; no pulse.
- Wrap and nibbles: 17 releases give o_Count=0x11, o_Tens_Nibble=1, o_Ones_Nibble=1. Preload to 0xFF via 255 releases; one more release gives 0x00 with a pulse.
- Clear priority: i_Clear=1 in the same cycle the release would increment, starting from 0x05. Result is o_Count=0x00 and o_Press_Pulse=0. The next release gives 0x01.
- Reset mid-debounce: raise i_Switch, then assert i_Rst_L=0 for 1 cycle after 3 cycles. o_Switch_Debounced stays 0 until 6 further held edges after reset release.
